cache: RTL and testbench
========================

Name: cache

Overview:
- Direct-mapped, read-only instruction cache between the fetch stage and the 64-bit Sysbus.
- Returns a 32-bit instruction for a 64-bit fetch address.
- On a miss, fetches a whole 64-byte line with one bus read request and eight response beats.
- Data-side inputs exist but are reserved (tied 0 by the core) in this revision.

Parameters:
- BUS_DATA_WIDTH, 64, bus request/response data width (line = 8 beats).
- BUS_TAG_WIDTH, 13, bus tag width.
- NUM_SETS, 64, number of cache lines (power of two; 4 KiB default).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- bus_reqcyc  out  1  bus request valid.
- bus_reqack  in  1  bus accepted request.
- bus_req  out  BUS_DATA_WIDTH  request payload (line address).
- bus_reqtag  out  BUS_TAG_WIDTH  request tag.
- bus_respcyc  in  1  response beat valid.
- bus_respack  out  1  response beat acknowledge.
- bus_resp  in  BUS_DATA_WIDTH  response beat data.
- bus_resptag  in  BUS_TAG_WIDTH  response tag (ignored).
- busy  out  1  requested instruction not yet available.
- instruction_read  in  1  fetch request.
- instruction_address  in  64  byte address of fetch (4-byte aligned).
- instruction_response  out  32  instruction word.
- mem_read  in  1  reserved data read; ignored.
- mem_write  in  1  reserved data write; ignored.

Behaviour:
- Address split: offset = addr[5:0], index = addr[6+log2(NUM_SETS)-1:6], tag = remaining upper bits. Word select = addr[5:2].
- Storage: per set, valid bit, tag, 16 x 32-bit words.
- Hit is combinational: instruction_read & valid[index] & tag match.
  - On a hit, busy=0 and instruction_response = the selected word, in the same cycle.
- busy = instruction_read & !hit, or state != IDLE.
- instruction_response is 0 when no hit.

FSM states: IDLE, REQ, RESP.
- IDLE: on instruction_read & miss, latch {tag, index} and go to REQ.
- REQ:
  - bus_reqcyc=1.
  - bus_req = {addr[63:6], 6'b0}.
  - bus_reqtag = {1'b1 (READ), 4'b0001 (MEMORY), 8'h00}.
  - Hold all three stable until bus_reqack=1, then go to RESP with beat counter 0.
- RESP:
  - bus_respack = bus_respcyc.
  - Each beat writes bus_resp into words 2k (bits [31:0]) and 2k+1 (bits [63:32]); k = beat counter, which then increments.
  - After beat 7: set valid, write tag, return to IDLE.
  - The next cycle the (unchanged) address hits.
- Miss latency: cycles in REQ until reqack, plus 8 respcyc beats, plus 1 cycle for the hit.
- Gaps between beats (respcyc=0) are allowed; the counter holds.
- The address may change during a fill; the fill completes for the latched line, then the current address is re-evaluated.
- Responses arriving in IDLE or REQ are acknowledged and discarded.

Reset:
- All valid bits cleared; state IDLE.
- bus_reqcyc=0, bus_respack=0, busy=0, instruction_response=0; counter 0.
- Reset mid-fill aborts the fill; the line stays invalid.
- Late beats after reset are acknowledged and discarded.

Optional Feature:
- CACHE_STATS_EN defined:
  - Adds output ports hit_count[31:0] and miss_count[31:0], both reset to 0.
  - hit_count increments on every cycle with instruction_read & hit.
  - miss_count increments on each IDLE->REQ transition.
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Cold miss: reset, instruction_read=1, addr=0x1000 → busy=1; reqcyc with bus_req=0x1000, reqtag=0x1100 held until reqack; 8 beats 0x(2k+1)_(2k) acknowledged → next cycle busy=0, response=0x00000000.
- Sequential hits: after the fill, step addr 0x1000..0x103C by 4 → busy=0 every cycle, response = word index (0..15), no bus activity.
- Next line: addr=0x1040 → new request with bus_req=0x1040. Conflict: addr=0x2000 (same index as 0x1000 for NUM_SETS=64) → evicts; refetching 0x1000 misses again.
- Stalled beats: insert 3 idle cycles between beats 3 and 4 → respack only with respcyc; fill correct; busy high throughout.
- Reset during RESP after beat 2: assert reset 1 cycle, then fetch 0x1000 → miss again, new request issued, stray beats acked and ignored.
- CACHE_STATS_EN: cold miss then 15 hits → miss_count=1, hit_count=16 (the post-fill hit counted).

Source files
------------

// File: rtl/cache.sv
// ---------------------------------------------------------------------------
// cache -- direct-mapped, read-only instruction cache
//
// Sits between the fetch stage and the 64-bit Sysbus. A fetch that hits
// returns its 32-bit word in the same cycle. A miss fetches the whole
// 64-byte line with one bus read request followed by eight response beats.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   bus_reqcyc/reqack     line read request handshake
//   bus_req, bus_reqtag   line address and request tag (READ, MEMORY)
//   bus_respcyc/respack   response beat handshake (every beat is acked)
//   bus_resp, bus_resptag response beat data; the tag is ignored
//   busy                  requested instruction not yet available
//   instruction_read      fetch request
//   instruction_address   byte address of the fetch (4-byte aligned)
//   instruction_response  fetched word, 0 when there is no hit
//   mem_read, mem_write   reserved data-side inputs, ignored
//   hit_count, miss_count saturating statistics (CACHE_STATS_EN only)
//
// Build option: define CACHE_STATS_EN to add the hit/miss counters.
//
// state  | meaning
// -------+------------------------------------------------------
// S_IDLE | serving hits; a miss latches the line and requests it
// S_REQ  | request held on the bus until bus_reqack
// S_RESP | collecting eight beats into the latched line
// ---------------------------------------------------------------------------
module cache #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int NUM_SETS       = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      bus_reqcyc,
    input  logic                      bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_respcyc,
    output logic                      bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      busy,
    input  logic                      instruction_read,
    input  logic [63:0]               instruction_address,
    output logic [31:0]               instruction_response,
    input  logic                      mem_read,
    input  logic                      mem_write
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]               hit_count,
    output logic [31:0]               miss_count
`endif
);

    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int LINE_W = 58;              // address bits above the 64-byte offset
    localparam int TAG_W  = LINE_W - IDX_W;
    localparam logic [BUS_TAG_WIDTH-1:0] REQ_TAG = BUS_TAG_WIDTH'(13'h1100);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t                    state_q;
    logic [NUM_SETS-1:0]       valid_q;
    logic [TAG_W-1:0]          tag_q  [NUM_SETS];
    logic [31:0]               data_q [NUM_SETS][16];
    logic [LINE_W-1:0]         line_q;
    logic [2:0]                beat_q;
    logic                      reqcyc_q;
    logic [BUS_DATA_WIDTH-1:0] req_q;
    logic [BUS_TAG_WIDTH-1:0]  reqtag_q;

    logic [IDX_W-1:0] addr_idx;
    logic [TAG_W-1:0] addr_tag;
    logic [3:0]       word_sel;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             hit;
    logic             miss_start;
    logic             beat_wr;

    assign addr_idx = instruction_address[6 +: IDX_W];
    assign addr_tag = instruction_address[63 -: TAG_W];
    assign word_sel = instruction_address[5:2];
    assign fill_idx = line_q[IDX_W-1:0];
    assign fill_tag = line_q[LINE_W-1 -: TAG_W];

    assign hit        = instruction_read & valid_q[addr_idx] & (tag_q[addr_idx] == addr_tag);
    assign miss_start = (state_q == S_IDLE) & instruction_read & ~hit & ~reset;
    assign beat_wr    = (state_q == S_RESP) & bus_respcyc & ~reset;

    // Outputs are forced quiet while reset is asserted; beats seen outside
    // S_RESP are still acknowledged so the bus never stalls on stray data.
    assign busy                 = ~reset & ((instruction_read & ~hit) | (state_q != S_IDLE));
    assign instruction_response = (hit & ~reset) ? data_q[addr_idx][word_sel] : 32'h0;
    assign bus_respack          = bus_respcyc & ~reset;
    assign bus_reqcyc           = reqcyc_q;
    assign bus_req              = req_q;
    assign bus_reqtag           = reqtag_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            valid_q  <= '0;
            line_q   <= '0;
            beat_q   <= 3'd0;
            reqcyc_q <= 1'b0;
            req_q    <= '0;
            reqtag_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (miss_start) begin
                        line_q   <= instruction_address[63:6];
                        req_q    <= BUS_DATA_WIDTH'({instruction_address[63:6], 6'b0});
                        reqtag_q <= REQ_TAG;
                        reqcyc_q <= 1'b1;
                        // The old line in this set is overwritten beat by beat,
                        // so it must stop hitting from now on.
                        valid_q[addr_idx] <= 1'b0;
                        state_q  <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus_reqack) begin
                        reqcyc_q <= 1'b0;
                        beat_q   <= 3'd0;
                        state_q  <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus_respcyc) begin
                        beat_q <= beat_q + 3'd1;
                        if (beat_q == 3'd7) begin
                            valid_q[fill_idx] <= 1'b1;
                            state_q           <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Line storage has no reset; valid_q alone decides whether it is usable.
    always_ff @(posedge clk) begin
        if (beat_wr) begin
            data_q[fill_idx][{beat_q, 1'b0}] <= bus_resp[31:0];
            data_q[fill_idx][{beat_q, 1'b1}] <= bus_resp[63:32];
            if (beat_q == 3'd7) begin
                tag_q[fill_idx] <= fill_tag;
            end
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= 32'h0;
            miss_count <= 32'h0;
        end else begin
            if (hit && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (miss_start && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

    logic unused_ok;
    assign unused_ok = ^{bus_resptag, mem_read, mem_write, instruction_address[1:0]};

endmodule

// File: tb/tb_cache.sv
// Bench for the instruction cache: directed scenarios followed by random
// fetches over a small pool of conflicting lines. The reference keeps a
// per-set valid/tag/word table derived from address arithmetic and the beats
// the bench itself delivered.
module tb_cache;
    localparam int NS = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
    logic [63:0] bus_req, bus_resp;
    logic [12:0] bus_reqtag, bus_resptag;
    logic        busy, instruction_read, mem_read, mem_write;
    logic [63:0] instruction_address;
    logic [31:0] instruction_response;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    cache dut (
        .clk(clk), .reset(reset),
        .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack), .bus_req(bus_req),
        .bus_reqtag(bus_reqtag), .bus_respcyc(bus_respcyc), .bus_respack(bus_respack),
        .bus_resp(bus_resp), .bus_resptag(bus_resptag), .busy(busy),
        .instruction_read(instruction_read), .instruction_address(instruction_address),
        .instruction_response(instruction_response),
        .mem_read(mem_read), .mem_write(mem_write)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    int          n_pass = 0;
    int          n_total = 0;
    int          n_fail = 0;
    int unsigned exp_hits = 0;
    int unsigned exp_miss = 0;

    bit          mv [NS];
    logic [63:0] mt [NS];
    logic [31:0] md [NS][16];

    function automatic int m_set(input logic [63:0] a);
        return int'((a >> 6) % 64'(NS));
    endfunction

    function automatic logic [63:0] m_tag(input logic [63:0] a);
        return a / 64'(64 * NS);
    endfunction

    function automatic bit m_hit(input logic [63:0] a);
        return mv[m_set(a)] && (mt[m_set(a)] == m_tag(a));
    endfunction

    function automatic logic [31:0] memw(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // Advance one clock; the hit/miss statistics model follows the inputs
    // that were presented during the cycle just ending.
    task automatic step();
        if (reset) begin
            exp_hits = 0;
            exp_miss = 0;
        end else if (instruction_read && m_hit(instruction_address)) begin
            if (exp_hits != 32'hFFFF_FFFF) exp_hits++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Serve a miss on address a (already presented and settled).
    task automatic fill(input logic [63:0] a, input int reqdly, input int gap_at,
                        input int gaplen, input bit pat, input int chg_at,
                        input logic [63:0] chg_a);
        int          n;
        int          s;
        logic [63:0] line;
        logic [63:0] beat;
        line = {a[63:6], 6'b0};
        s    = m_set(a);
        chk("miss_busy", 64'(busy), 64'(1));
        chk("miss_resp", 64'(instruction_response), 64'(0));
        step();
        n = 0;
        while (!bus_reqcyc && n < 16) begin
            step();
            n++;
        end
        chk("req_seen", 64'(bus_reqcyc), 64'(1));
        if (bus_reqcyc) begin
            mv[s] = 1'b0;
            if (exp_miss != 32'hFFFF_FFFF) exp_miss++;
            chk("req_addr", bus_req, line);
            chk("req_tag", 64'(bus_reqtag), 64'(13'h1100));
            for (int d = 0; d < reqdly; d++) begin
                step();
                chk("req_hold_cyc", 64'(bus_reqcyc), 64'(1));
                chk("req_hold_addr", bus_req, line);
                chk("req_hold_tag", 64'(bus_reqtag), 64'(13'h1100));
                chk("req_busy", 64'(busy), 64'(1));
            end
            bus_reqack = 1'b1;
            step();
            bus_reqack = 1'b0;
            chk("req_drop", 64'(bus_reqcyc), 64'(0));
            for (int k = 0; k < 8; k++) begin
                if (k == chg_at) instruction_address = chg_a;
                if (k == gap_at) begin
                    for (int g = 0; g < gaplen; g++) begin
                        bus_respcyc = 1'b0;
                        settle();
                        chk("gap_respack", 64'(bus_respack), 64'(0));
                        chk("gap_busy", 64'(busy), 64'(1));
                        step();
                    end
                end
                beat = pat ? {32'(2 * k + 1), 32'(2 * k)}
                           : {memw(line + 64'(8 * k + 4)), memw(line + 64'(8 * k))};
                bus_resp    = beat;
                bus_respcyc = 1'b1;
                settle();
                chk("beat_respack", 64'(bus_respack), 64'(1));
                chk("beat_busy", 64'(busy), 64'(1));
                md[s][2 * k]     = beat[31:0];
                md[s][2 * k + 1] = beat[63:32];
                step();
            end
            bus_respcyc = 1'b0;
            mv[s] = 1'b1;
            mt[s] = m_tag(a);
        end
        settle();
    endtask

    // Fetch a: check a hit directly, or serve the miss and check the hit after.
    task automatic access(input logic [63:0] a, input int reqdly, input int gap_at,
                          input int gaplen);
        instruction_read    = 1'b1;
        instruction_address = a;
        settle();
        if (!m_hit(a)) fill(a, reqdly, gap_at, gaplen, 1'b0, -1, 64'h0);
        chk("hit_busy", 64'(busy), 64'(0));
        chk("hit_resp", 64'(instruction_response), 64'(md[m_set(a)][int'(a[5:2])]));
        step();
    endtask

    logic [63:0] pool [6];

    initial begin
        reset = 1'b1;
        bus_reqack = 1'b0;
        bus_respcyc = 1'b1;
        bus_resp = 64'hDEAD_BEEF_DEAD_BEEF;
        bus_resptag = 13'h0;
        instruction_read = 1'b0;
        instruction_address = 64'h1000;
        mem_read = 1'b0;
        mem_write = 1'b0;
        for (int i = 0; i < NS; i++) mv[i] = 1'b0;
        step();
        step();
        settle();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_reqcyc", 64'(bus_reqcyc), 64'(0));
        chk("rst_respack", 64'(bus_respack), 64'(0));
        chk("rst_resp", 64'(instruction_response), 64'(0));
        step();
`ifdef CACHE_STATS_EN
        chk("rst_hit_count", 64'(hit_count), 64'(0));
        chk("rst_miss_count", 64'(miss_count), 64'(0));
`endif
        reset = 1'b0;
        bus_respcyc = 1'b0;

        // Cold miss with a two-cycle request stall, pattern data 0x(2k+1)_(2k).
        instruction_read = 1'b1;
        instruction_address = 64'h1000;
        settle();
        fill(64'h1000, 2, -1, 0, 1'b1, -1, 64'h0);
        for (int i = 0; i < 16; i++) begin
            instruction_address = 64'h1000 + 64'(4 * i);
            settle();
            chk("seq_busy", 64'(busy), 64'(0));
            chk("seq_resp", 64'(instruction_response), 64'(i));
            chk("seq_nobus", 64'(bus_reqcyc), 64'(0));
            step();
        end
`ifdef CACHE_STATS_EN
        chk("stats_hit16", 64'(hit_count), 64'(16));
        chk("stats_miss1", 64'(miss_count), 64'(1));
`endif

        instruction_read = 1'b0;
        settle();
        chk("noread_busy", 64'(busy), 64'(0));
        chk("noread_resp", 64'(instruction_response), 64'(0));
        step();

        access(64'h1040, 0, -1, 0);
        access(64'h2000, 1, -1, 0);
        instruction_address = 64'h1000;
        settle();
        chk("evicted_busy", 64'(busy), 64'(1));
        fill(64'h1000, 0, -1, 0, 1'b1, -1, 64'h0);
        chk("refill_resp", 64'(instruction_response), 64'(0));
        step();

        access(64'h30C8, 0, 4, 3);

        // Address moves to another valid line mid-fill; fill still completes.
        instruction_address = 64'h5080;
        settle();
        fill(64'h5080, 1, -1, 0, 1'b0, 3, 64'h1004);
        chk("chg_busy", 64'(busy), 64'(0));
        chk("chg_resp", 64'(instruction_response), 64'(1));
        step();
        access(64'h50BC, 0, -1, 0);

        // Reset during the response phase after beat 2.
        instruction_address = 64'h6000;
        settle();
        step();
        for (int n = 0; n < 16 && !bus_reqcyc; n++) step();
        chk("rr_req_seen", 64'(bus_reqcyc), 64'(1));
        chk("rr_req_addr", bus_req, 64'h6000);
        mv[0] = 1'b0;
        bus_reqack = 1'b1;
        step();
        bus_reqack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus_resp = 64'hBAD0_0000_0000_0000 | 64'(k);
            bus_respcyc = 1'b1;
            step();
        end
        reset = 1'b1;
        settle();
        chk("rr_busy", 64'(busy), 64'(0));
        chk("rr_respack", 64'(bus_respack), 64'(0));
        step();
        for (int i = 0; i < NS; i++) mv[i] = 1'b0;
        reset = 1'b0;
        instruction_read = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("stray_respack", 64'(bus_respack), 64'(1));
            chk("stray_reqcyc", 64'(bus_reqcyc), 64'(0));
            chk("stray_busy", 64'(busy), 64'(0));
            step();
        end
        bus_respcyc = 1'b0;
        access(64'h6000, 0, -1, 0);
        access(64'h1004, 0, -1, 0);

        // Random fetches over lines that share sets.
        pool[0] = 64'h1000;
        pool[1] = 64'h1040;
        pool[2] = 64'h2000;
        pool[3] = 64'h30C0;
        pool[4] = 64'hFFFF_FFFF_FFFF_FFC0;
        pool[5] = 64'h8000_0000_0000_1040;
        for (int it = 0; it < 40; it++) begin
            access(pool[$urandom_range(0, 5)] + 64'(4 * $urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 11)),
                   int'($urandom_range(1, 2)));
        end
`ifdef CACHE_STATS_EN
        chk("stats_hits", 64'(hit_count), 64'(exp_hits));
        chk("stats_misses", 64'(miss_count), 64'(exp_miss));
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
